// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and types for the round-robin 4:1 mux arbiter.
package rr_mux_arbiter_pkg;
   localparam int N_CH  = 4;
   localparam int SEL_W = 2;
   localparam int MUX_W = 4;

   typedef logic [SEL_W-1:0] sel_t;

   // Modulo-4 increment; the wrap 3 -> 0 falls out of the 2-bit width.
   function automatic sel_t sel_inc(sel_t s);
      return sel_t'(s + sel_t'(1));
   endfunction
endpackage

// File: rtl/mux_4_1.sv
// Existing 4-bit 4:1 multiplexer used as the arbiter's datapath.
module mux_4_1
   import rr_mux_arbiter_pkg::*;
(
   input  logic [MUX_W-1:0] d0_i,
   input  logic [MUX_W-1:0] d1_i,
   input  logic [MUX_W-1:0] d2_i,
   input  logic [MUX_W-1:0] d3_i,
   input  sel_t             sel_i,
   output logic [MUX_W-1:0] y_o
);
   always_comb begin
      case (sel_i)
         2'd0:    y_o = d0_i;
         2'd1:    y_o = d1_i;
         2'd2:    y_o = d2_i;
         default: y_o = d3_i;
      endcase
   end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over four channels feeding a single-entry output register
// through the 4:1 mux; loads whenever the register is empty or being drained.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] in_valid,
   input  logic [W-1:0]    in_data0,
   input  logic [W-1:0]    in_data1,
   input  logic [W-1:0]    in_data2,
   input  logic [W-1:0]    in_data3,
   output logic [N_CH-1:0] in_ready,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
   output logic [1:0]      out_sel,
   input  logic            out_ready
);
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   sel_t         out_sel_q, out_sel_d;
   sel_t         ptr_q, ptr_d;

   logic         load;
   logic         any_valid;
   logic         found;
   sel_t         winner;
   sel_t         cand;
   logic [W-1:0] mux_y;

   assign load      = !out_valid_q || out_ready;
   assign any_valid = |in_valid;

   // First requester at or after the pointer, scanning upward modulo 4.
   always_comb begin
      winner = ptr_q;
      found  = 1'b0;
      cand   = ptr_q;
      for (int k = 0; k < N_CH; k++) begin
         cand = sel_t'(ptr_q + sel_t'(k));
         if (!found && in_valid[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   mux_4_1 u_mux (
      .d0_i  (in_data0),
      .d1_i  (in_data1),
      .d2_i  (in_data2),
      .d3_i  (in_data3),
      .sel_i (winner),
      .y_o   (mux_y)
   );

   // Grant is gated by rst_n so no channel sees an accept while in reset.
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
         assign in_ready[gi] = rst_n && load && any_valid && (winner == sel_t'(gi));
      end
   endgenerate

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (load) begin
         if (any_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_y;
            out_sel_d   = winner;
            ptr_d       = sel_inc(winner);
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench: fixed vector table, a hand sequence, then random traffic
// compared each cycle against a behavioural round-robin model.
module tb_rr_mux_arbiter;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   in_valid;
   logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
   logic [3:0]   in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   out_sel;
   logic         out_ready;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Behavioural model state
   bit           m_valid;
   logic [W-1:0] m_data;
   int           m_sel;
   int           m_ptr;

   typedef struct {
      logic       rst_n;
      logic [3:0] iv;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_v;
      logic [1:0] exp_sel;
      logic [3:0] exp_data;
   } vec_t;

   vec_t tbl[22];

   rr_mux_arbiter #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data0  (in_data0),
      .in_data1  (in_data1),
      .in_data2  (in_data2),
      .in_data3  (in_data3),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   function automatic int rr_winner(logic [3:0] req, int p);
      for (int k = 0; k < 4; k++) begin
         if (req[(p + k) % 4]) return (p + k) % 4;
      end
      return 0;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Called at posedge+1 with inputs already driven; returns at next posedge+1.
   task automatic cycle();
      logic [3:0]   er;
      bit           ld;
      int           w;
      logic [W-1:0] d[4];
      #2;
      d[0] = in_data0; d[1] = in_data1; d[2] = in_data2; d[3] = in_data3;
      ld = !m_valid || out_ready;
      w  = rr_winner(in_valid, m_ptr);
      er = (rst_n && ld && (in_valid != 4'b0)) ? 4'(1 << w) : 4'b0;
      check("in_ready", 32'(in_ready), 32'(er));
      check("in_ready_onehot0", 32'($onehot0(in_ready)), 32'd1);
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_sel", 32'(out_sel), 32'(m_sel));
      $display("cyc %0d rst_n=%0b iv=%b ordy=%0b rdy=%b | ov=%0b od=%h os=%0d",
               cyc, rst_n, in_valid, out_ready, in_ready, out_valid, out_data, out_sel);
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
      end else if (ld) begin
         if (in_valid != 4'b0) begin
            m_valid = 1; m_data = d[w]; m_sel = w; m_ptr = (w + 1) % 4;
         end else begin
            m_valid = 0;
         end
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
      tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
      tbl[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
      tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
      tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
      tbl[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
      tbl[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
      tbl[7]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
      tbl[8]  = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
      tbl[9]  = '{1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
      tbl[10] = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
      tbl[11] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 4'hB};
      tbl[12] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 4'hA};
      tbl[13] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 4'hA};
      tbl[14] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 4'hA};
      tbl[15] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 4'hA};
      tbl[16] = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
      tbl[17] = '{1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
      tbl[18] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0};
      tbl[19] = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
      tbl[20] = '{1'b1, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
      tbl[21] = '{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b1, 2'd2, 4'hC};

      rst_n = 1'b0; in_valid = 4'b0; out_ready = 1'b0;
      in_data0 = 4'hA; in_data1 = 4'hB; in_data2 = 4'hC; in_data3 = 4'hD;
      @(posedge clk); @(posedge clk); #1;
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;

      // Reset state, with requests present to confirm no grant leaks out.
      in_valid = 4'b1111; out_ready = 1'b1;
      cycle();
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_out_sel", 32'(out_sel), 32'd0);

      for (int i = 0; i < 22; i++) begin
         rst_n = tbl[i].rst_n; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
         #2;
         check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
         cycle();
         check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
         check($sformatf("tbl%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].exp_sel));
         check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_data));
      end

      // Back-to-back replacement: old word drains while a new one loads.
      rst_n = 1'b1; in_valid = 4'b0001; out_ready = 1'b1; in_data0 = 4'h5;
      cycle();
      check("b2b_first_data", 32'(out_data), 32'h5);
      in_data0 = 4'h6;
      cycle();
      check("b2b_second_data", 32'(out_data), 32'h6);
      check("b2b_second_sel", 32'(out_sel), 32'd0);
      check("b2b_valid", 32'(out_valid), 32'd1);

      for (int i = 0; i < 400; i++) begin
         rst_n     = ($urandom_range(0, 39) != 0);
         in_valid  = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         in_data0  = 4'($urandom_range(0, 15));
         in_data1  = 4'($urandom_range(0, 15));
         in_data2  = 4'($urandom_range(0, 15));
         in_data3  = 4'($urandom_range(0, 15));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter W, default 4, is the per-channel data width; only W=4 is supported, to match the 4-bit 4:1 mux datapath.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low; sampled only on the rising edge of clk.
REQ-004 in_valid  input  4  per-channel request; bit i means channel i holds valid data.
REQ-005 in_data0..in_data3  input  W each  channel payloads.
REQ-006 in_ready  output  4  per-channel accept; one-hot or zero.
REQ-007 out_valid  output  1  registered output holds a valid word.
REQ-008 out_data  output  W  registered selected payload.
REQ-009 out_sel  output  2  registered index of the channel that produced out_data.
REQ-010 out_ready  input  1  downstream accepts the output word.

Function
REQ-011 A channel transfer occurs in a cycle where in_valid[i] and in_ready[i] are both 1; an output transfer occurs where out_valid and out_ready are both 1.
REQ-012 Load enable: load = !out_valid || out_ready, a single-entry pipeline register with no bubble on back-to-back traffic.
REQ-013 Arbitration is round-robin: search from pointer ptr (2-bit), ptr, ptr+1, ptr+2, ptr+3 mod 4; the first set in_valid bit wins.
REQ-014 in_ready[i] = load && (i == winner) && (in_valid != 0); at most one bit is set.
REQ-015 on a channel transfer, next cycle: out_valid=1, out_data=in_data[winner], out_sel=winner, ptr=(winner+1) mod 4, with wrap 3 -> 0.
REQ-016 If load=1 and in_valid=0: out_valid becomes 0; out_data, out_sel and ptr hold.
REQ-017 If load=0 (out_valid=1, out_ready=0): out_valid, out_data, out_sel and ptr hold; in_ready=0.
REQ-018 Latency is 1 cycle from channel transfer to out_valid; sustained throughput is 1 word/cycle when out_ready=1.
REQ-019 Output transfer and a new channel transfer in the same cycle: the new word replaces the old one, with no loss and no duplication.
REQ-020 in_data of a non-granted channel never reaches out_data; in_valid deasserting without a transfer is legal and causes no state change.
REQ-021 out_data, out_sel and out_valid are driven only from flops; in_ready is combinational from in_valid, ptr, out_valid and out_ready.

Reset
REQ-022 While rst_n=0 at a rising edge: out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-023 in_ready=0 in any cycle where rst_n=0, regardless of other inputs.
REQ-024 Reset asserted mid-operation discards any held output word; the first grant after release goes to the lowest requesting channel starting from 0.

Structure
REQ-025 Package rr_mux_arbiter_pkg holds localparam N_CH=4, SEL_W=2, and typedef sel_t (logic [1:0]).
REQ-026 The data path reuses the existing 4-bit 4:1 mux as sub-module mux_4_1, with sel driven by the combinational winner; the arbiter adds only the pointer, the winner logic and the output register.
REQ-027 No other sub-modules are used; the winner search is one combinational block.

Verification
REQ-028 After reset with in_valid=4'b1111 and out_ready=1 held for 8 cycles: out_sel sequence is 0,1,2,3,0,1,2,3 and out_data matches in_data0..3 = a,b,c,d.
REQ-029 in_valid=4'b1010 with ptr=0: first grant is 1, then 3, then 1; channels 0 and 2 never get in_ready.
REQ-030 out_ready=0 for 3 cycles with in_valid=4'b0001: in_ready=0 in those cycles and out_data=held value; on out_ready=1, the next word transfers in the same cycle.
REQ-031 in_valid=0 with out_ready=1 after one word: out_valid drops to 0 the next cycle, and out_sel is unchanged.
REQ-032 rst_n=0 asserted while out_valid=1 and ptr=2: next cycle out_valid=0 and ptr=0; after release with in_valid=4'b0101, the first grant is 0.
REQ-033 Each cycle, the bench checks that in_ready is one-hot or zero and matches a reference round-robin model.
